cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
Sequencing controller for the direct-mapped L1 data cache array in the RISC-V core. It sits between the CPU load/store port, the cache tag/data array and the backing memory. Read hits are served from the array. Read misses trigger a full-line refill burst followed by a replay. Writes are write-through, no-write-allocate.

Parameters:
LINE_WORDS, 4, words per cache line; power of two, at least 2.
XLEN, 32, address and data width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held stable with addr, we and wdata while cpu_stall=1
cpu_we  in  1  1=store, 0=load
cpu_addr  in  XLEN  word-aligned byte address
cpu_wdata  in  XLEN  store data
cpu_stall  out  1  request not accepted this cycle (combinational)
cpu_done  out  1  registered one-cycle pulse, one cycle after acceptance
cpu_rdata  out  XLEN  registered load data, valid with cpu_done
arr_hit  in  1  array lookup of cpu_addr (combinational in array)
arr_rdata  in  XLEN  array word at cpu_addr
arr_fill_en  out  1  write arr_fill_data at arr_fill_addr
arr_fill_addr  out  XLEN  refill word address
arr_fill_data  out  XLEN  refill word
arr_fill_last  out  1  final refill word; array sets tag and valid only on this pulse
arr_wr_en  out  1  store-hit update, using cpu_addr and cpu_wdata
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_ack  in  1  word transfer complete; sampled only while mem_req=1
mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- Reset (asynchronous): state=IDLE, word counter=0. All outputs 0, including cpu_done, cpu_rdata, mem_* and arr_*.
- Acceptance: a request is accepted on any rising edge where cpu_req=1 and cpu_stall=0.
- FSM states: IDLE, REFILL, WRITE_MEM, WRITE_DONE.
- IDLE, read hit (cpu_req & !cpu_we & arr_hit):
  - cpu_stall=0.
  - cpu_rdata<=arr_rdata and cpu_done<=1 at the next edge.
  - Back-to-back hits sustain one per cycle.
- IDLE, read miss:
  - cpu_stall=1.
  - Latch line base (word-offset bits [log2(LINE_WORDS)+1:2] cleared) and counter=0.
  - Transition to REFILL.
- REFILL:
  - cpu_stall=1, mem_req=1, mem_we=0, mem_addr=base+4*counter.
  - On mem_ack: arr_fill_en=1 in the same cycle, fill_addr=mem_addr, fill_data=mem_rdata; counter increments.
  - On the ack with counter==LINE_WORDS-1: arr_fill_last=1, then transition to IDLE.
  - The replay in IDLE then hits and completes as a normal hit.
- IDLE, write:
  - cpu_stall=1.
  - Latch addr and data, transition to WRITE_MEM.
- WRITE_MEM:
  - cpu_stall=1, mem_req=1, mem_we=1, mem_addr and mem_wdata come from the latch.
  - On mem_ack, transition to WRITE_DONE.
- WRITE_DONE:
  - cpu_stall=0, so the held store is accepted.
  - arr_wr_en=arr_hit.
  - cpu_done pulses at the next edge, then transition to IDLE.
- Miss store: no allocation (arr_wr_en=0).
- mem_ack in the same cycle mem_req first rises is legal; consecutive acks are legal.
- Reset mid-REFILL: no arr_fill_last is issued, so a partial line stays invalid. The controller returns to IDLE immediately.
- cpu_req=0 in IDLE: no outputs are asserted and the state holds.

Optional Feature:
CACHE_WBUF_EN. When defined, a single-entry posted write buffer is added:
- IDLE store with buffer empty: accepted with cpu_stall=0, arr_wr_en=arr_hit, cpu_done next cycle, and the entry is loaded.
- The buffer drains via mem_req/mem_we in the background.
- A store with the buffer full stalls until the drain's mem_ack.
- A read miss stalls until the buffer is empty, then starts REFILL. Ordering: the drain always precedes the refill.
- A read hit proceeds while draining.

When the macro is undefined, stores use the blocking WRITE_MEM/WRITE_DONE path above.

Decomposition:
- Package cache_pkg holds:
  - ctrl_state_t enum;
  - LINE_WORDS and derived OFFSET_BITS=$clog2(LINE_WORDS);
  - function line_base(addr).
- One sub-module, cache_wbuf: the buffer entry plus its drain handshake. It is instantiated only under CACHE_WBUF_EN.

Test Plan:
- Reset then read hit, arr_hit=1, arr_rdata=0xDEADBEEF, addr 0x100 -> cpu_stall=0, next cycle cpu_done=1 and cpu_rdata=0xDEADBEEF, mem_req never asserted.
- Read miss at 0x1008 (LINE_WORDS=4), acks 2 cycles apart with data 0xA0..0xA3 -> mem_addr 0x1000, 0x1004, 0x1008, 0x100C; 4 arr_fill_en pulses, arr_fill_last on the 4th; with arr_hit=1 the replay gives cpu_done and cpu_rdata=0xA2.
- Store hit at 0x200 with data 0x12345678, ack after 3 cycles -> mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; WRITE_DONE gives arr_wr_en=1, then cpu_done. Store miss -> arr_wr_en=0.
- Reset asserted after 2 of 4 refill acks -> all outputs 0 at once, arr_fill_last never seen, next access starts from IDLE.
- Three consecutive read hits -> three consecutive cpu_done pulses, cpu_stall stays 0.
- CACHE_WBUF_EN: store 0x300, then read miss 0x400 in the next cycle -> store accepted without stall; read stalls until the 0x300 write is acked, then refill starts at 0x400.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 data cache miss controller: controller state
// encoding, line geometry and the line-base address helper.
package cache_pkg;

   localparam int LINE_WORDS  = 4;
   localparam int OFFSET_BITS = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REFILL     = 2'd1,
      WRITE_MEM  = 2'd2,
      WRITE_DONE = 2'd3
   } ctrl_state_t;

   // Clear the word-offset and byte-offset bits so the address points at the
   // first word of its cache line.
   function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_bits);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << (off_bits + 2);
      return addr & mask;
   endfunction

endpackage

// File: rtl/cache_miss_ctrl_wbuf.sv
// cache_wbuf: single-entry posted write buffer used by cache_miss_ctrl when
// CACHE_WBUF_EN is defined. Holds one store and presents it to memory as a
// write request until the memory acknowledges it.
module cache_wbuf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] load_addr,
   input  logic [XLEN-1:0] load_data,
   input  logic            mem_ack,
   output logic            full,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata
);

   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] data_q;

   // Entry capture on a posted store, release on the drain acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (load) begin
         full   <= 1'b1;
         addr_q <= load_addr;
         data_q <= load_data;
      end else if (full && mem_ack) begin
         full   <= 1'b0;
      end
   end

   assign mem_req   = full;
   assign mem_addr  = full ? addr_q : '0;
   assign mem_wdata = full ? data_q : '0;

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: sequencing controller for the direct-mapped L1 data cache.
// Read hits complete in one cycle, read misses refill a full line from memory
// and then replay as a hit, stores are write-through without allocation.
// Optional feature macro: CACHE_WBUF_EN adds a single-entry posted write
// buffer (cache_wbuf) so stores no longer block on the memory write.
module cache_miss_ctrl #(
   parameter int LINE_WORDS = 4,
   parameter int XLEN       = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [XLEN-1:0] cpu_addr,
   input  logic [XLEN-1:0] cpu_wdata,
   output logic            cpu_stall,
   output logic            cpu_done,
   output logic [XLEN-1:0] cpu_rdata,
   input  logic            arr_hit,
   input  logic [XLEN-1:0] arr_rdata,
   output logic            arr_fill_en,
   output logic [XLEN-1:0] arr_fill_addr,
   output logic [XLEN-1:0] arr_fill_data,
   output logic            arr_fill_last,
   output logic            arr_wr_en,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   import cache_pkg::*;

   localparam int               CNT_W    = $clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

   ctrl_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] refill_addr;
   logic            rd_hit;
   logic            rd_miss;
   logic            wr_req;
   logic            refill_end;

   assign rd_hit      = cpu_req & ~cpu_we & arr_hit;
   assign rd_miss     = cpu_req & ~cpu_we & ~arr_hit;
   assign wr_req      = cpu_req & cpu_we;
   assign refill_addr = base + XLEN'({cnt, 2'b00});
   assign refill_end  = (state == REFILL) & mem_ack & (cnt == CNT_LAST);

`ifdef CACHE_WBUF_EN
   logic            wbuf_full;
   logic            wbuf_load;
   logic            wbuf_req;
   logic [XLEN-1:0] wbuf_addr;
   logic [XLEN-1:0] wbuf_data;

   // A store is posted only from IDLE and only into an empty entry; the refill
   // never overlaps a drain, so the ack is routed to the buffer outside REFILL.
   assign wbuf_load = (state == IDLE) & wr_req & ~wbuf_full;

   cache_wbuf #(.XLEN(XLEN)) u_wbuf (
      .clk       (clk),
      .reset     (reset),
      .load      (wbuf_load),
      .load_addr (cpu_addr),
      .load_data (cpu_wdata),
      .mem_ack   (mem_ack & (state != REFILL)),
      .full      (wbuf_full),
      .mem_req   (wbuf_req),
      .mem_addr  (wbuf_addr),
      .mem_wdata (wbuf_data)
   );
`endif

   // Controller FSM with registered CPU response (cpu_done, cpu_rdata).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         base      <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cpu_done  <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_done <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_hit) begin
                  cpu_done  <= 1'b1;
                  cpu_rdata <= arr_rdata;
               end else if (rd_miss) begin
`ifdef CACHE_WBUF_EN
                  // The pending drain must reach memory before the refill.
                  if (!wbuf_full) begin
                     base  <= XLEN'(line_base(32'(cpu_addr), CNT_W));
                     cnt   <= '0;
                     state <= REFILL;
                  end
`else
                  base  <= XLEN'(line_base(32'(cpu_addr), CNT_W));
                  cnt   <= '0;
                  state <= REFILL;
`endif
               end else if (wr_req) begin
`ifdef CACHE_WBUF_EN
                  if (!wbuf_full) begin
                     cpu_done <= 1'b1;
                  end
`else
                  wr_addr <= cpu_addr;
                  wr_data <= cpu_wdata;
                  state   <= WRITE_MEM;
`endif
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            WRITE_MEM: begin
               if (mem_ack) begin
                  state <= WRITE_DONE;
               end
            end
            WRITE_DONE: begin
               if (cpu_req) begin
                  cpu_done <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Per-state decode of stall, memory and array controls; forced quiet in reset.
   always_comb begin
      cpu_stall     = 1'b0;
      arr_fill_en   = 1'b0;
      arr_fill_addr = '0;
      arr_fill_data = '0;
      arr_fill_last = 1'b0;
      arr_wr_en     = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      if (!reset) begin
         case (state)
            IDLE: begin
`ifdef CACHE_WBUF_EN
               cpu_stall = rd_miss | (wr_req & wbuf_full);
               arr_wr_en = wbuf_load & arr_hit;
               mem_req   = wbuf_req;
               mem_we    = wbuf_req;
               mem_addr  = wbuf_addr;
               mem_wdata = wbuf_data;
`else
               cpu_stall = rd_miss | wr_req;
`endif
            end
            REFILL: begin
               cpu_stall     = 1'b1;
               mem_req       = 1'b1;
               mem_addr      = refill_addr;
               arr_fill_en   = mem_ack;
               arr_fill_addr = refill_addr;
               arr_fill_data = mem_ack ? mem_rdata : '0;
               arr_fill_last = refill_end;
            end
            WRITE_MEM: begin
               cpu_stall = 1'b1;
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = wr_addr;
               mem_wdata = wr_data;
            end
            WRITE_DONE: begin
               arr_wr_en = cpu_req & arr_hit;
            end
            default: cpu_stall = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl (LINE_WORDS=4, XLEN=32). Load
// results are pushed to a scoreboard queue when the request is driven and
// popped when cpu_done is seen. The CACHE_WBUF_EN scenarios are compiled only
// when that macro is defined.
module tb_cache_miss_ctrl;

   typedef struct {
      bit          chk;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_stall;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        arr_hit = 1'b0;
   logic [31:0] arr_rdata = '0;
   logic        arr_fill_en;
   logic [31:0] arr_fill_addr;
   logic [31:0] arr_fill_data;
   logic        arr_fill_last;
   logic        arr_wr_en;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic [166:0] all_out;
   logic [31:0]  cap [0:3];
   bit           cap_valid;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   fill_cnt = 0;
   int   last_cnt = 0;
   int   memreq_cnt = 0;

   cache_miss_ctrl #(.LINE_WORDS(4), .XLEN(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_req       (cpu_req),
      .cpu_we        (cpu_we),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_stall     (cpu_stall),
      .cpu_done      (cpu_done),
      .cpu_rdata     (cpu_rdata),
      .arr_hit       (arr_hit),
      .arr_rdata     (arr_rdata),
      .arr_fill_en   (arr_fill_en),
      .arr_fill_addr (arr_fill_addr),
      .arr_fill_data (arr_fill_data),
      .arr_fill_last (arr_fill_last),
      .arr_wr_en     (arr_wr_en),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   assign all_out = {cpu_stall, cpu_done, cpu_rdata, arr_fill_en, arr_fill_addr,
                     arr_fill_data, arr_fill_last, arr_wr_en, mem_req, mem_we,
                     mem_addr, mem_wdata};

   always #5 clk = ~clk;

   // Small array model: remembers refilled words, line becomes valid on last.
   always @(posedge clk) begin
      if (reset) begin
         cap_valid <= 1'b0;
      end else begin
         if (arr_fill_en === 1'b1) cap[arr_fill_addr[3:2]] <= arr_fill_data;
         if (arr_fill_last === 1'b1) cap_valid <= 1'b1;
      end
   end

   // One clock cycle: sample pre-edge strobes, advance, then retire cpu_done.
   task automatic tick();
      exp_t e;
      #1;
      if (arr_fill_en === 1'b1) fill_cnt++;
      if (arr_fill_last === 1'b1) last_cnt++;
      if (mem_req === 1'b1) memreq_cnt++;
      @(posedge clk);
      #1;
      if (cpu_done === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: cpu_done=1 with empty scoreboard at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (e.chk && cpu_rdata !== e.data) begin
               n_fail++;
               $display("FAIL sb_rdata: cpu_rdata=%h expected %h", cpu_rdata, e.data);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: outputs=%h expected 0", all_out);
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; arr_hit = 1'b0;
      #1;
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_with_req: outputs=%h expected 0", all_out);
      end
      cpu_req = 1'b0;
      reset = 1'b0;
      tick();
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL idle_no_req: outputs=%h expected 0", all_out);
      end
   endtask

   task automatic test_read_hit();
      int m0;
      m0 = memreq_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
      arr_hit = 1'b1; arr_rdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_stall: cpu_stall=%b expected 0", cpu_stall);
      end
      exp_q.push_back('{1'b1, 32'hDEADBEEF});
      tick();
      cpu_req = 1'b0; arr_hit = 1'b0; arr_rdata = '0;
      n_checks++;
      if (cpu_done !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_done: cpu_done=%b expected 1", cpu_done);
      end
      tick();
      n_checks++;
      if (cpu_done !== 1'b0 || memreq_cnt != m0) begin
         n_fail++;
         $display("FAIL hit_quiet: cpu_done=%b mem_req cycles=%0d expected 0/0", cpu_done, memreq_cnt - m0);
      end
   endtask

   task automatic test_read_miss();
      int f0, l0;
      logic [31:0] ea;
      f0 = fill_cnt; l0 = last_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1008; arr_hit = 1'b0;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL miss_stall: cpu_stall=%b expected 1", cpu_stall);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         ea = 32'h1000 + 32'(4 * k);
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea || arr_fill_en !== 1'b0 || cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_wait[%0d]: req=%b we=%b addr=%h fill=%b stall=%b expected 1/0/%h/0/1",
                     k, mem_req, mem_we, mem_addr, arr_fill_en, cpu_stall, ea);
         end
         tick();
         mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(k);
         #1;
         n_checks++;
         if (arr_fill_en !== 1'b1 || arr_fill_addr !== ea || arr_fill_data !== 32'hA0 + 32'(k) ||
             arr_fill_last !== (k == 3)) begin
            n_fail++;
            $display("FAIL refill_ack[%0d]: fill_en=%b addr=%h data=%h last=%b expected 1/%h/%h/%b",
                     k, arr_fill_en, arr_fill_addr, arr_fill_data, arr_fill_last, ea, 32'hA0 + 32'(k), k == 3);
         end
         tick();
         mem_ack = 1'b0; mem_rdata = '0;
      end
      arr_hit = cap_valid; arr_rdata = cap[cpu_addr[3:2]];
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL replay_stall: cpu_stall=%b mem_req=%b expected 0/0", cpu_stall, mem_req);
      end
      exp_q.push_back('{1'b1, 32'hA2});
      tick();
      cpu_req = 1'b0; arr_hit = 1'b0; arr_rdata = '0;
      n_checks++;
      if (cpu_done !== 1'b1 || fill_cnt - f0 != 4 || last_cnt - l0 != 1) begin
         n_fail++;
         $display("FAIL refill_totals: done=%b fills=%0d lasts=%0d expected 1/4/1",
                  cpu_done, fill_cnt - f0, last_cnt - l0);
      end
      tick();
   endtask

   task automatic test_store();
`ifdef CACHE_WBUF_EN
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h12345678; arr_hit = 1'b1;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0 || arr_wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL wb_store_accept: stall=%b wr_en=%b expected 0/1", cpu_stall, arr_wr_en);
      end
      exp_q.push_back('{1'b0, 32'h0});
      tick();
      cpu_req = 1'b0; arr_hit = 1'b0;
      n_checks++;
      if (cpu_done !== 1'b1) begin
         n_fail++;
         $display("FAIL wb_store_done: cpu_done=%b expected 1", cpu_done);
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wb_drain[%0d]: req=%b we=%b addr=%h wdata=%h expected 1/1/200/12345678",
                     c, mem_req, mem_we, mem_addr, mem_wdata);
         end
         if (c == 2) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h204; cpu_wdata = 32'h55; arr_hit = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || arr_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL wb_store_miss: req=%b stall=%b wr_en=%b expected 0/0/0", mem_req, cpu_stall, arr_wr_en);
      end
      exp_q.push_back('{1'b0, 32'h0});
      tick();
      cpu_req = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
`else
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h12345678; arr_hit = 1'b1;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b1 || arr_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL store_stall: stall=%b wr_en=%b expected 1/0", cpu_stall, arr_wr_en);
      end
      tick();
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678 ||
             cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL store_mem[%0d]: req=%b we=%b addr=%h wdata=%h stall=%b expected 1/1/200/12345678/1",
                     c, mem_req, mem_we, mem_addr, mem_wdata, cpu_stall);
         end
         if (c == 2) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0 || arr_wr_en !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL store_done_hit: stall=%b wr_en=%b req=%b expected 0/1/0", cpu_stall, arr_wr_en, mem_req);
      end
      exp_q.push_back('{1'b0, 32'h0});
      tick();
      cpu_req = 1'b0; arr_hit = 1'b0;
      #1;
      n_checks++;
      if (cpu_done !== 1'b1 || arr_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL store_done_pulse: done=%b wr_en=%b expected 1/0", cpu_done, arr_wr_en);
      end
      // Store miss with the ack arriving as soon as mem_req rises.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h204; cpu_wdata = 32'h55; arr_hit = 1'b0;
      tick();
      mem_ack = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'h55) begin
         n_fail++;
         $display("FAIL store_miss_mem: req=%b addr=%h wdata=%h expected 1/204/55", mem_req, mem_addr, mem_wdata);
      end
      tick();
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0 || arr_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL store_miss_noalloc: stall=%b wr_en=%b expected 0/0", cpu_stall, arr_wr_en);
      end
      exp_q.push_back('{1'b0, 32'h0});
      tick();
      cpu_req = 1'b0;
      tick();
`endif
   endtask

   task automatic test_reset_mid_refill();
      int l0;
      l0 = last_cnt;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2004; arr_hit = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         mem_ack = 1'b1; mem_rdata = 32'hB0 + 32'(k);
         tick();
      end
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h2008) begin
         n_fail++;
         $display("FAIL partial_refill: req=%b addr=%h expected 1/2008", mem_req, mem_addr);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL async_reset: outputs=%h expected 0", all_out);
      end
      tick();
      reset = 1'b0;
      cpu_req = 1'b0;
      tick();
      n_checks++;
      if (last_cnt != l0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_last: fill_last pulses=%0d mem_req=%b expected 0/0", last_cnt - l0, mem_req);
      end
      cpu_req = 1'b1; cpu_addr = 32'h40; arr_hit = 1'b1; arr_rdata = 32'h77;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_hit: cpu_stall=%b expected 0", cpu_stall);
      end
      exp_q.push_back('{1'b1, 32'h77});
      tick();
      cpu_req = 1'b0; arr_hit = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [0:2];
      d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333;
      for (int i = 0; i < 3; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10 + 32'(4 * i);
         arr_hit = 1'b1; arr_rdata = d[i];
         #1;
         n_checks++;
         if (cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall[%0d]: cpu_stall=%b expected 0", i, cpu_stall);
         end
         exp_q.push_back('{1'b1, d[i]});
         tick();
         n_checks++;
         if (cpu_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done[%0d]: cpu_done=%b expected 1", i, cpu_done);
         end
      end
      cpu_req = 1'b0; arr_hit = 1'b0;
      tick();
      n_checks++;
      if (cpu_done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: cpu_done=%b expected 0", cpu_done);
      end
   endtask

`ifdef CACHE_WBUF_EN
   task automatic test_wbuf_order();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'hCAFE0300; arr_hit = 1'b1;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL wbuf_store_stall: cpu_stall=%b expected 0", cpu_stall);
      end
      exp_q.push_back('{1'b0, 32'h0});
      tick();
      cpu_we = 1'b0; cpu_addr = 32'h400; arr_hit = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (cpu_stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL wbuf_drain_first[%0d]: stall=%b req=%b we=%b addr=%h expected 1/1/1/300",
                     c, cpu_stall, mem_req, mem_we, mem_addr);
         end
         tick();
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL wbuf_gap: stall=%b req=%b expected 1/0", cpu_stall, mem_req);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         mem_ack = 1'b1; mem_rdata = 32'hC0 + 32'(k);
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h400 + 32'(4 * k)) begin
            n_fail++;
            $display("FAIL wbuf_refill[%0d]: req=%b we=%b addr=%h expected 1/0/%h",
                     k, mem_req, mem_we, mem_addr, 32'h400 + 32'(4 * k));
         end
         tick();
      end
      mem_ack = 1'b0;
      arr_hit = cap_valid; arr_rdata = cap[0];
      exp_q.push_back('{1'b1, 32'hC0});
      tick();
      cpu_req = 1'b0; arr_hit = 1'b0;
      tick();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_hit();
      test_read_miss();
      test_store();
      test_reset_mid_refill();
      test_back_to_back();
`ifdef CACHE_WBUF_EN
      test_wbuf_order();
`endif
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d responses never seen, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
